// File: rtl/rsp_s2_prep_phase_rotate.sv
// Phase rotator: aligns buffered samples with lagging twiddles and emits the
// rounded, saturated complex product d * w through a 4-stage pipeline.
module rsp_s2_prep_phase_rotate #(
    parameter int DATA_WIDTH    = 64,
    parameter int TWIDDLE_WIDTH = 64,
    parameter int FRAC_BITS     = 30,
    parameter int FIFO_DEPTH    = 8,
    parameter int DATA_NUM      = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic                     i_data_valid,
    input  logic                     i_data_last,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic                     i_phase_w_valid,
    input  logic [TWIDDLE_WIDTH-1:0] i_phase_w,
    output logic                     o_data_valid,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_data_last,
    output logic                     o_frame_done,
    output logic                     o_fifo_ovf,
    output logic                     o_phase_unf,
    output logic                     o_len_err,
    output logic                     o_sat
);
    localparam int HW = DATA_WIDTH / 2;
    localparam int TW = TWIDDLE_WIDTH / 2;
    localparam int PW = HW + TW;
    localparam int SW = PW + 1;
    localparam int RW = PW + 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_NUM);
    localparam logic signed [RW-1:0] RND  = RW'(1) << (FRAC_BITS - 1);
    localparam logic signed [RW-1:0] MAXV = (RW'(1) << (HW - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MINV = -(RW'(1) << (HW - 1));
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_NUM - 1);

    // Alignment FIFO; pointers carry one wrap bit to tell full from empty
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                empty, full, pop, push;
    logic [DATA_WIDTH:0] rd_entry;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = i_phase_w_valid && !empty && !i_start;
    assign push     = i_data_valid && !i_start && (!full || pop);
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {i_data_last, i_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_fifo_ovf  <= 1'b0;
            o_phase_unf <= 1'b0;
        end else if (i_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (i_data_valid && full && !pop) o_fifo_ovf  <= 1'b1;
            if (i_phase_w_valid && empty)     o_phase_unf <= 1'b1;
        end
    end

    // Datapath registers free-run; only the valid chain is qualified
    logic signed [HW-1:0] dr, di;
    logic signed [TW-1:0] wr, wi;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [SW-1:0] acc_re, acc_im;

    always_ff @(posedge clk) begin
        if (pop) begin
            dr <= rd_entry[DATA_WIDTH-1:HW];
            di <= rd_entry[HW-1:0];
            wr <= i_phase_w[TWIDDLE_WIDTH-1:TW];
            wi <= i_phase_w[TW-1:0];
        end
        p_rr   <= PW'(dr) * PW'(wr);
        p_ii   <= PW'(di) * PW'(wi);
        p_ri   <= PW'(dr) * PW'(wi);
        p_ir   <= PW'(di) * PW'(wr);
        acc_re <= SW'(p_rr) - SW'(p_ii);
        acc_im <= SW'(p_ri) + SW'(p_ir);
    end

    // Returns {clamped, value}: round half up, then clamp to HW-bit signed range
    function automatic logic [HW:0] rnd_sat(input logic signed [SW-1:0] x);
        logic signed [RW-1:0] r;
        r = (RW'(x) + RND) >>> FRAC_BITS;
        if (r > MAXV)      rnd_sat = {1'b1, MAXV[HW-1:0]};
        else if (r < MINV) rnd_sat = {1'b1, MINV[HW-1:0]};
        else               rnd_sat = {1'b0, r[HW-1:0]};
    endfunction

    logic [HW:0]   re_rs, im_rs;
    logic [3:1]    vld_pipe, last_pipe;
    logic [CW-1:0] cnt;

    assign re_rs = rnd_sat(acc_re);
    assign im_rs = rnd_sat(acc_im);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe     <= '0;
            last_pipe    <= '0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_data_last  <= 1'b0;
            o_frame_done <= 1'b0;
            o_len_err    <= 1'b0;
            o_sat        <= 1'b0;
            cnt          <= '0;
        end else if (i_start) begin
            vld_pipe     <= '0;
            o_data_valid <= 1'b0;
            o_data_last  <= 1'b0;
            o_frame_done <= 1'b0;
            cnt          <= '0;
        end else begin
            vld_pipe     <= {vld_pipe[2], vld_pipe[1], pop};
            last_pipe    <= {last_pipe[2], last_pipe[1], rd_entry[DATA_WIDTH]};
            o_data_valid <= vld_pipe[3];
            o_data_last  <= vld_pipe[3] & last_pipe[3];
            o_frame_done <= vld_pipe[3] & last_pipe[3];
            if (vld_pipe[3]) begin
                o_data <= {re_rs[HW-1:0], im_rs[HW-1:0]};
                if (re_rs[HW] || im_rs[HW]) o_sat <= 1'b1;
                // A frame ends either on last or on reaching DATA_NUM samples
                if (last_pipe[3]) begin
                    cnt <= '0;
                    if (cnt != LAST_IDX) o_len_err <= 1'b1;
                end else if (cnt == LAST_IDX) begin
                    cnt       <= '0;
                    o_len_err <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_rsp_s2_prep_phase_rotate.sv
// Directed bench for the phase rotator with a reference FIFO/complex-multiply
// model feeding an expected-output scoreboard.
module tb_rsp_s2_prep_phase_rotate;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_data_valid = 1'b0;
    logic        i_data_last = 1'b0;
    logic [63:0] i_data = '0;
    logic        i_phase_w_valid = 1'b0;
    logic [63:0] i_phase_w = '0;
    logic        o_data_valid, o_data_last, o_frame_done;
    logic [63:0] o_data;
    logic        o_fifo_ovf, o_phase_unf, o_len_err, o_sat;

    rsp_s2_prep_phase_rotate dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .i_data_valid(i_data_valid), .i_data_last(i_data_last), .i_data(i_data),
        .i_phase_w_valid(i_phase_w_valid), .i_phase_w(i_phase_w),
        .o_data_valid(o_data_valid), .o_data(o_data), .o_data_last(o_data_last),
        .o_frame_done(o_frame_done), .o_fifo_ovf(o_fifo_ovf), .o_phase_unf(o_phase_unf),
        .o_len_err(o_len_err), .o_sat(o_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        last;
        int          due;
    } exp_t;

    logic [64:0] mq[$];
    exp_t        eq[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          n_out = 0;
    int          n_mark;
    logic [63:0] last_out = '0;
    logic [63:0] w_id  = 64'h40000000_00000000;
    logic [63:0] w_90  = 64'h00000000_40000000;

    function automatic logic [31:0] clamp(input logic signed [69:0] x);
        logic signed [69:0] y;
        y = (x + 70'sd536870912) >>> 30;
        if (y > 70'sd2147483647)  return 32'h7FFFFFFF;
        if (y < -70'sd2147483648) return 32'h80000000;
        return y[31:0];
    endfunction

    function automatic logic [63:0] rot(input logic [63:0] d, input logic [63:0] w);
        logic signed [69:0] dr, di, wr, wi;
        dr = 70'($signed(d[63:32]));
        di = 70'($signed(d[31:0]));
        wr = 70'($signed(w[63:32]));
        wi = 70'($signed(w[31:0]));
        return {clamp(dr * wr - di * wi), clamp(dr * wi + di * wr)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (o_data_valid === 1'b1) begin
            n_out++;
            last_out = o_data;
            chk("out_expected", {63'd0, eq.size() != 0}, 64'd1);
            if (eq.size() != 0) begin
                e = eq.pop_front();
                chk("out_data", o_data, e.data);
                chk("out_last", {63'd0, o_data_last}, {63'd0, e.last});
                chk("out_frame_done", {63'd0, o_frame_done}, {63'd0, e.last});
                chk("out_latency", 64'(cyc), 64'(e.due));
            end
        end else begin
            chk("idle_last_done", {62'd0, o_data_last, o_frame_done}, 64'd0);
            if (eq.size() != 0 && eq[0].due <= cyc) begin
                chk("out_missing", {63'd0, o_data_valid}, 64'd1);
                void'(eq.pop_front());
            end
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge
    task automatic step(input logic dv, input logic dl, input logic [63:0] d,
                        input logic pv, input logic [63:0] w);
        logic [64:0] s;
        i_data_valid = dv; i_data_last = dl; i_data = d;
        i_phase_w_valid = pv; i_phase_w = w;
        if (rst_n) begin
            if (pv && mq.size() > 0) begin
                s = mq.pop_front();
                eq.push_back('{rot(s[63:0], w), s[64], cyc + 3});
            end
            if (dv && mq.size() < 8) mq.push_back({dl, d});
        end
        @(posedge clk); #1;
        check_out();
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_start();
        i_start = 1'b1;
        i_data_valid = 1'b1; i_data = 64'hDEAD_BEEF_0BAD_F00D; i_data_last = 1'b0;
        i_phase_w_valid = 1'b1; i_phase_w = w_id;
        mq.delete(); eq.delete();
        @(posedge clk); #1;
        check_out();
        cyc++;
        i_start = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk("rst_valid", {63'd0, o_data_valid}, 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_flags", {58'd0, o_data_last, o_frame_done, o_fifo_ovf, o_phase_unf, o_len_err, o_sat}, 64'd0);
        rst_n = 1'b1;
        idle(2);

        // Identity rotation
        step(1'b1, 1'b0, 64'h000003E8_FFFFF830, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1, w_id);
        idle(5);
        chk("identity", last_out, 64'h000003E8_FFFFF830);
        chk("identity_flags", {60'd0, o_fifo_ovf, o_phase_unf, o_len_err, o_sat}, 64'd0);

        // 90 degrees
        step(1'b1, 1'b0, 64'h000003E8_00000000, 1'b0, '0);
        step(1'b1, 1'b0, 64'h00000000_000003E8, 1'b1, w_90);
        step(1'b0, 1'b0, '0, 1'b1, w_90);
        idle(3);
        chk("rot90_b", last_out, 64'hFFFFFC18_00000000);

        // Round half up, then saturation
        step(1'b1, 1'b0, 64'h00000003_FFFFFFFD, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 64'h20000000_00000000);
        idle(5);
        chk("round", last_out, 64'h00000002_FFFFFFFF);
        chk("no_sat_yet", {63'd0, o_sat}, 64'd0);
        step(1'b1, 1'b0, 64'h7FFFFFFF_7FFFFFFF, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1, 64'h40000000_40000000);
        idle(5);
        chk("sat_re", {32'd0, last_out[63:32]}, 64'd0);
        chk("sat_im", {32'd0, last_out[31:0]}, 64'h7FFFFFFF);
        chk("sat_flag", {63'd0, o_sat}, 64'd1);

        // Full frame, twiddle lagging by 4
        do_start();
        n_mark = n_out;
        for (int i = 0; i < 1028; i++)
            step(i < 1024, i == 1023, {$urandom, $urandom}, i >= 4, {$urandom, $urandom});
        idle(5);
        chk("frame_count", 64'(n_out - n_mark), 64'd1024);
        chk("frame_len_ok", {63'd0, o_len_err}, 64'd0);

        // Restart mid-frame: in-flight samples vanish, counter restarts
        do_start();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, {$urandom, $urandom}, i >= 2, w_id);
        n_mark = n_out;
        do_start();
        idle(6);
        chk("restart_no_out", 64'(n_out), 64'(n_mark));
        for (int i = 0; i < 1026; i++)
            step(i < 1024, i == 1023, {$urandom, $urandom}, i >= 2, w_90);
        idle(5);
        chk("restart_frame_count", 64'(n_out - n_mark), 64'd1024);
        chk("restart_len_ok", {63'd0, o_len_err}, 64'd0);

        // Overflow and underflow
        do_start();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 64'(i) << 32, 1'b0, '0);
        chk("ovf_before", {63'd0, o_fifo_ovf}, 64'd0);
        step(1'b1, 1'b0, 64'hFFFF_0000_0000_0000, 1'b0, '0);
        chk("ovf_set", {63'd0, o_fifo_ovf}, 64'd1);
        n_mark = n_out;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, w_id);
        idle(4);
        chk("ovf_out_count", 64'(n_out - n_mark), 64'd8);
        chk("unf_before", {63'd0, o_phase_unf}, 64'd0);
        step(1'b0, 1'b0, '0, 1'b1, w_id);
        idle(5);
        chk("unf_set", {63'd0, o_phase_unf}, 64'd1);
        chk("unf_no_out", 64'(n_out - n_mark), 64'd8);

        // Short frame; sticky flags survive i_start
        do_start();
        chk("sticky_after_start", {62'd0, o_fifo_ovf, o_phase_unf}, 64'd3);
        chk("short_len_before", {63'd0, o_len_err}, 64'd0);
        for (int i = 0; i < 102; i++)
            step(i < 100, i == 99, {$urandom, $urandom}, i >= 2, w_id);
        idle(5);
        chk("short_len_err", {63'd0, o_len_err}, 64'd1);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, {$urandom, $urandom}, i >= 1, w_id);
        #2 rst_n = 1'b0;
        #1;
        mq.delete(); eq.delete();
        chk("arst_valid", {63'd0, o_data_valid}, 64'd0);
        chk("arst_data", o_data, 64'd0);
        chk("arst_flags", {60'd0, o_fifo_ovf, o_phase_unf, o_len_err, o_sat}, 64'd0);
        step(1'b1, 1'b0, 64'h1, 1'b1, w_id);
        rst_n = 1'b1;
        n_mark = n_out;
        idle(6);
        chk("arst_no_out", 64'(n_out), 64'(n_mark));
        step(1'b1, 1'b0, 64'h00000005_00000007, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b1, w_id);
        idle(5);
        chk("arst_resume", last_out, 64'h00000005_00000007);
        chk("drain", 64'(eq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
